// File: rtl/urv_writeback_pkg.sv
// Shared encodings for the writeback stage: load funct3 codes, result-source
// selects and the data-phase state machine states.
package urv_writeback_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    localparam logic [1:0] RD_SOURCE_ALU      = 2'b00;
    localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'b01;
    localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'b10;
    localparam logic [1:0] RD_SOURCE_DIVIDE   = 2'b11;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/urv_writeback_load_align.sv
// Load data alignment: picks the byte/half-word lane out of the AHB read word
// and sign- or zero-extends it according to funct3.
module urv_load_align
    import urv_writeback_pkg::*;
(
    input  logic [2:0]  fun,
    input  logic [1:0]  addr,
    input  logic [31:0] hrdata,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr)
            2'd0:    lane_b = hrdata[7:0];
            2'd1:    lane_b = hrdata[15:8];
            2'd2:    lane_b = hrdata[23:16];
            default: lane_b = hrdata[31:24];
        endcase
        lane_h = addr[1] ? hrdata[31:16] : hrdata[15:0];
    end

    always_comb begin
        case (fun)
            LDST_B:  data = {{24{lane_b[7]}}, lane_b};
            LDST_BU: data = {24'h0, lane_b};
            LDST_H:  data = {{16{lane_h[15]}}, lane_h};
            LDST_HU: data = {16'h0, lane_h};
            LDST_L:  data = hrdata;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/urv_writeback.sv
// Writeback stage: finishes the AHB-Lite data phase, selects the rd result and
// registers the register-file write port, plus error capture and retire count.
module urv_writeback
    import urv_writeback_pkg::*;
#(
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    w_stall_i,
    input  logic [2:0]              w_fun_i,
    input  logic                    w_load_i,
    input  logic                    w_store_i,
    input  logic                    w_valid_i,
    input  logic [4:0]              w_rd_i,
    input  logic [31:0]             w_rd_value_i,
    input  logic                    w_rd_write_i,
    input  logic [31:0]             w_dm_addr_i,
    input  logic [1:0]              w_rd_source_i,
    input  logic [31:0]             w_rd_shifter_i,
    input  logic [31:0]             w_rd_multiply_i,
    input  logic [31:0]             HRDATA,
    input  logic                    HREADY,
    input  logic                    HRESP,
    output logic                    w_stall_req_o,
    output logic [4:0]              rf_rd_o,
    output logic [31:0]             rf_rd_value_o,
    output logic                    rf_rd_write_o,
    output logic                    w_bypass_valid_o,
    output logic                    bus_err_o,
    output logic [31:0]             bus_err_addr_o,
    output logic [RETIRE_CNT_W-1:0] retired_o
);

    wb_state_t   state;
    logic        act;
    logic        commit;
    logic        err;
    logic [31:0] load_data;
    logic [31:0] result;

    urv_load_align u_align (
        .fun    (w_fun_i),
        .addr   (w_dm_addr_i[1:0]),
        .hrdata (HRDATA),
        .data   (load_data)
    );

    assign act           = (w_load_i | w_store_i) & w_valid_i;
    assign w_stall_req_o = act & ~HREADY;
    assign commit        = ~w_stall_i & ~w_stall_req_o;
    assign err           = act & HREADY & HRESP;

    always_comb begin
        if (w_load_i)
            result = load_data;
        else if (w_rd_source_i == RD_SOURCE_SHIFTER)
            result = w_rd_shifter_i;
        else if (w_rd_source_i == RD_SOURCE_MULTIPLY)
            result = w_rd_multiply_i;
        else
            result = w_rd_value_i;
    end

    assign w_bypass_valid_o = rf_rd_write_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= W_IDLE;
        end else begin
            case (state)
                W_IDLE:  if (act & ~HREADY) state <= W_WAIT;
                W_WAIT:  if (HREADY) state <= W_IDLE;
                default: state <= W_IDLE;
            endcase
        end
    end

    // The write strobe is a single-cycle pulse: any non-commit edge clears it
    // so a stalled instruction cannot write twice.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rf_rd_o       <= 5'd0;
            rf_rd_value_o <= 32'h0;
            rf_rd_write_o <= 1'b0;
            retired_o     <= '0;
        end else if (commit) begin
            rf_rd_o       <= w_rd_i;
            rf_rd_value_o <= result;
            rf_rd_write_o <= w_rd_write_i & w_valid_i & (w_rd_i != 5'd0) & ~(act & HRESP);
            if (w_valid_i)
                retired_o <= retired_o + {{(RETIRE_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            rf_rd_write_o <= 1'b0;
        end
    end

    // Only the first failing address is kept; the flag itself is sticky.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus_err_o      <= 1'b0;
            bus_err_addr_o <= 32'h0;
        end else if (err & ~w_stall_i) begin
            bus_err_o <= 1'b1;
            if (!bus_err_o)
                bus_err_addr_o <= w_dm_addr_i;
        end
    end

endmodule

// File: tb/tb_urv_writeback.sv
// Directed bench for urv_writeback: load alignment, wait states, rd select,
// bus errors, stalls and reset during a wait.
module tb_urv_writeback;
    import urv_writeback_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        w_stall_i = 1'b0;
    logic [2:0]  w_fun_i = 3'd0;
    logic        w_load_i = 1'b0;
    logic        w_store_i = 1'b0;
    logic        w_valid_i = 1'b0;
    logic [4:0]  w_rd_i = 5'd0;
    logic [31:0] w_rd_value_i = 32'h0;
    logic        w_rd_write_i = 1'b0;
    logic [31:0] w_dm_addr_i = 32'h0;
    logic [1:0]  w_rd_source_i = 2'd0;
    logic [31:0] w_rd_shifter_i = 32'h0;
    logic [31:0] w_rd_multiply_i = 32'h0;
    logic [31:0] HRDATA = 32'h0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic        w_stall_req_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_write_o;
    logic        w_bypass_valid_o;
    logic        bus_err_o;
    logic [31:0] bus_err_addr_o;
    logic [31:0] retired_o;

    int checks = 0;
    int errors = 0;

    urv_writeback #(.RETIRE_CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .w_stall_i(w_stall_i), .w_fun_i(w_fun_i),
        .w_load_i(w_load_i), .w_store_i(w_store_i), .w_valid_i(w_valid_i),
        .w_rd_i(w_rd_i), .w_rd_value_i(w_rd_value_i), .w_rd_write_i(w_rd_write_i),
        .w_dm_addr_i(w_dm_addr_i), .w_rd_source_i(w_rd_source_i),
        .w_rd_shifter_i(w_rd_shifter_i), .w_rd_multiply_i(w_rd_multiply_i),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .w_stall_req_o(w_stall_req_o), .rf_rd_o(rf_rd_o), .rf_rd_value_o(rf_rd_value_o),
        .rf_rd_write_o(rf_rd_write_o), .w_bypass_valid_o(w_bypass_valid_o),
        .bus_err_o(bus_err_o), .bus_err_addr_o(bus_err_addr_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        w_valid_i = 1'b0; w_load_i = 1'b0; w_store_i = 1'b0;
        w_rd_write_i = 1'b0; HREADY = 1'b1; HRESP = 1'b0; w_stall_i = 1'b0;
    endtask

    task automatic load(input logic [2:0] fun, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd);
        w_fun_i = fun; w_dm_addr_i = addr; HRDATA = data; w_rd_i = rd;
        w_load_i = 1'b1; w_store_i = 1'b0; w_valid_i = 1'b1; w_rd_write_i = 1'b1;
    endtask

    initial begin
        #12;
        chk("rst_rd", {27'h0, rf_rd_o}, 32'h0);
        chk("rst_val", rf_rd_value_o, 32'h0);
        chk("rst_wr", {31'h0, rf_rd_write_o}, 32'h0);
        chk("rst_err", {31'h0, bus_err_o}, 32'h0);
        chk("rst_ret", retired_o, 32'h0);
        @(negedge clk_i); rst_i = 1'b1;
        @(posedge clk_i); #1;

        // LB from the top byte lane, sign extension
        load(LDST_B, 32'h0000_1003, 32'h80FF_1234, 5'd3);
        tick();
        chk("lb_val", rf_rd_value_o, 32'hFFFF_FF80);
        chk("lb_wr", {31'h0, rf_rd_write_o}, 32'h1);
        chk("lb_byp", {31'h0, w_bypass_valid_o}, 32'h1);
        chk("lb_rd", {27'h0, rf_rd_o}, 32'd3);
        chk("lb_ret", retired_o, 32'd1);
        idle(); tick();
        chk("lb_pulse", {31'h0, rf_rd_write_o}, 32'h0);

        // LH sign extension and LBU zero extension
        load(LDST_H, 32'h0000_0000, 32'h1234_8001, 5'd4);
        tick();
        chk("lh_val", rf_rd_value_o, 32'hFFFF_8001);
        load(LDST_BU, 32'h0000_0001, 32'h0000_F500, 5'd4);
        tick();
        chk("lbu_val", rf_rd_value_o, 32'h0000_00F5);
        chk("lbu_ret", retired_o, 32'd3);

        // LHU with three wait states
        load(LDST_HU, 32'h0000_1002, 32'h9ABC_0000, 5'd6);
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("lhu_streq", {31'h0, w_stall_req_o}, 32'h1);
            tick();
            chk("lhu_nowr", {31'h0, rf_rd_write_o}, 32'h0);
        end
        HREADY = 1'b1;
        #1 chk("lhu_streq_lo", {31'h0, w_stall_req_o}, 32'h0);
        tick();
        chk("lhu_val", rf_rd_value_o, 32'h0000_9ABC);
        chk("lhu_wr", {31'h0, rf_rd_write_o}, 32'h1);
        chk("lhu_ret", retired_o, 32'd4);
        idle(); tick();
        chk("lhu_pulse", {31'h0, rf_rd_write_o}, 32'h0);

        // Multiply result, then the same op targeting x0
        w_valid_i = 1'b1; w_rd_write_i = 1'b1; w_rd_i = 5'd5;
        w_rd_source_i = RD_SOURCE_MULTIPLY; w_rd_multiply_i = 32'h0000_0C00;
        w_rd_value_i = 32'hDEAD_BEEF; w_rd_shifter_i = 32'h1111_1111;
        tick();
        chk("mul_rd", {27'h0, rf_rd_o}, 32'd5);
        chk("mul_val", rf_rd_value_o, 32'h0000_0C00);
        chk("mul_wr", {31'h0, rf_rd_write_o}, 32'h1);
        w_rd_i = 5'd0;
        tick();
        chk("x0_wr", {31'h0, rf_rd_write_o}, 32'h0);
        chk("x0_ret", retired_o, 32'd6);
        w_rd_i = 5'd8; w_rd_source_i = RD_SOURCE_SHIFTER;
        tick();
        chk("shf_val", rf_rd_value_o, 32'h1111_1111);

        // Bus errors: first address sticks
        load(LDST_L, 32'h2000_0010, 32'h5555_5555, 5'd7);
        HRESP = 1'b1;
        tick();
        chk("err_wr", {31'h0, rf_rd_write_o}, 32'h0);
        chk("err_flag", {31'h0, bus_err_o}, 32'h1);
        chk("err_addr", bus_err_addr_o, 32'h2000_0010);
        chk("err_ret", retired_o, 32'd8);
        w_load_i = 1'b0; w_store_i = 1'b1; w_dm_addr_i = 32'h3000_0000;
        tick();
        chk("err2_addr", bus_err_addr_o, 32'h2000_0010);
        chk("err2_flag", {31'h0, bus_err_o}, 32'h1);
        idle(); tick();

        // Global stall holds an ALU op for two cycles
        w_valid_i = 1'b1; w_rd_write_i = 1'b1; w_rd_i = 5'd9;
        w_rd_source_i = RD_SOURCE_ALU; w_rd_value_i = 32'h0000_1234;
        w_stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stl_wr", {31'h0, rf_rd_write_o}, 32'h0);
            chk("stl_ret", retired_o, 32'd9);
        end
        w_stall_i = 1'b0;
        tick();
        chk("stl_rel_wr", {31'h0, rf_rd_write_o}, 32'h1);
        chk("stl_rel_val", rf_rd_value_o, 32'h0000_1234);
        chk("stl_rel_ret", retired_o, 32'd10);
        idle(); tick();
        chk("stl_pulse", {31'h0, rf_rd_write_o}, 32'h0);

        // Reset while waiting on HREADY
        load(LDST_L, 32'h0000_0040, 32'hCAFE_F00D, 5'd10);
        HREADY = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        chk("rwait_wr", {31'h0, rf_rd_write_o}, 32'h0);
        chk("rwait_val", rf_rd_value_o, 32'h0);
        chk("rwait_ret", retired_o, 32'h0);
        chk("rwait_err", {31'h0, bus_err_o}, 32'h0);
        chk("rwait_eaddr", bus_err_addr_o, 32'h0);
        idle();
        #2 rst_i = 1'b1;
        tick();
        chk("rwait_post_wr", {31'h0, rf_rd_write_o}, 32'h0);
        chk("rwait_post_ret", retired_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/urv_writeback.md
Name: urv_writeback

Overview:
- Final pipeline stage; consumes the X/W pipeline registers produced by the execute stage.
- Completes the AHB-Lite data phase: captures HRDATA for loads, waits on HREADY, and flags HRESP errors.
- Selects the final rd value (load/ALU-path/shifter/multiply), aligns and sign-extends load data, and registers the register-file write port.
- Also provides a bypass copy of the write port and a retired-instruction counter.

Parameters:
- RETIRE_CNT_W, 32, width of retired-instruction counter (wraps at 2^RETIRE_CNT_W).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- w_stall_i  in  1  global pipeline stall (hold all state)
- w_fun_i  in  3  load/store/ALU funct3 from execute
- w_load_i  in  1  load in W
- w_store_i  in  1  store in W
- w_valid_i  in  1  W instruction valid
- w_rd_i  in  5  destination register
- w_rd_value_i  in  32  ALU/divide/CSR result
- w_rd_write_i  in  1  rd write enable
- w_dm_addr_i  in  32  load/store address
- w_rd_source_i  in  2  result source select
- w_rd_shifter_i  in  32  shifter result
- w_rd_multiply_i  in  32  multiplier result
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB data-phase ready
- HRESP  in  1  AHB error response
- w_stall_req_o  out  1  stall request while data phase incomplete
- rf_rd_o  out  5  RF write index (registered)
- rf_rd_value_o  out  32  RF write data (registered)
- rf_rd_write_o  out  1  RF write strobe (registered)
- w_bypass_valid_o  out  1  equals rf_rd_write_o; bypass to decode
- bus_err_o  out  1  sticky AHB error flag
- bus_err_addr_o  out  32  address of first erroring access
- retired_o  out  RETIRE_CNT_W  retired-instruction count

Behaviour:
- Reset (rst_i=0, async): all outputs 0; state=IDLE.
- Active transfer: act = (w_load_i | w_store_i) & w_valid_i.
- State machine:
  - IDLE: if act & !HREADY -> WAIT.
  - WAIT: stays until HREADY=1, then returns to IDLE the same edge.
  - w_stall_req_o = act & !HREADY (combinational, in both states).
- Load alignment, selected by w_fun_i and w_dm_addr_i[1:0]:
  - LB (000) / LBU (100): byte lane addr[1:0]; LB sign-extends, LBU zero-extends.
  - LH (001) / LHU (101): half-word lane addr[1]; LH sign-extends, LHU zero-extends.
  - LW (010): HRDATA unchanged.
  - Other codes: result 0.
- Result mux:
  - w_load_i: aligned load data.
  - Otherwise `RD_SOURCE_SHIFTER -> w_rd_shifter_i; `RD_SOURCE_MULTIPLY -> w_rd_multiply_i; else w_rd_value_i.
- Commit edge: !w_stall_i & !w_stall_req_o.
  - rf_rd_o <= w_rd_i; rf_rd_value_o <= result.
  - rf_rd_write_o <= w_rd_write_i & w_valid_i & (rd != 0) & !(act & HRESP).
- Non-commit edge: rf_rd_write_o <= 0; rf_rd_o and rf_rd_value_o hold. A single write therefore never repeats during a stall.
- Latency: result appears on rf_* one cycle after the data phase completes.
- Bus error (act & HREADY & HRESP):
  - Suppresses the rd write.
  - Sets bus_err_o (sticky until reset).
  - Loads bus_err_addr_o only if bus_err_o was 0, so the first error address is kept.
- retired_o increments by 1 on each commit edge with w_valid_i=1, including erroring accesses. It wraps to 0.
- Simultaneous w_stall_i and HREADY in WAIT: state returns to IDLE, no commit. The next unstalled edge commits using the HRDATA present on that edge. The AHB slave holds HRDATA while HREADY=1 and no new address phase is issued; upstream stall guarantees this.
- Reset mid-WAIT: state -> IDLE, no write issued.

Decomposition:
- Shared defines in kmkz_defs.v: `LDST_B/H/L/BU/HU funct3 codes, `RD_SOURCE_* encodings, state encodings W_IDLE/W_WAIT.
- One sub-module urv_load_align (combinational): inputs fun, addr[1:0], HRDATA; output aligned 32-bit value.
- FSM, commit registers, error capture and counter live in urv_writeback.

Test Plan:
- LB, addr=0x...3, HRDATA=0x80FF_1234, HREADY=1 -> next cycle rf_rd_value_o=0xFFFF_FF80, rf_rd_write_o=1 for one cycle.
- LHU, addr=0x...2, HRDATA=0x9ABC_0000, HREADY low 3 cycles -> w_stall_req_o high 3 cycles, single write 0x0000_9ABC after HREADY rises, retired_o +1.
- ALU op, w_rd_source_i=`RD_SOURCE_MULTIPLY, w_rd_multiply_i=0x0000_0C00, rd=x5 -> rf_rd_o=5, value 0x0C00; same op with rd=x0 -> rf_rd_write_o stays 0.
- LW to 0x2000_0010 with HRESP=1 -> no RF write, bus_err_o=1, bus_err_addr_o=0x2000_0010; second error at 0x3000_0000 leaves address unchanged.
- Assert rst_i low during WAIT -> all outputs 0 immediately, no write after release.
- Hold w_stall_i=1 for 2 cycles with valid ALU op -> no rf write, retired_o unchanged; release -> exactly one write.
